// File: rtl/s1_wr_arbiter.sv
// Round-robin write arbiter locking slave S1 to one master for a full AW/W/B transaction.
// Latency: grant registered 1 cycle after request; handshakes pass through combinationally (0 cycles).
// Backpressure: S1 READY/VALID pass straight to the granted master; all other masters see READY=0/BVALID=0.
//
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   M_AW*/M_W*/M_B*          per-master handshakes, one bit per master
//   S1_AW*/S1_W*/S1_B*       single shared S1 write channel
//   grant_idx, grant_oh      registered grant (mux select / one-hot, zero when idle)
//   busy                     transaction in progress
//   bid_err                  sticky: B master-index field differed from the granted master
module s1_wr_arbiter #(
  parameter int NUM_M     = 4,
  parameter int MIDX_W    = 2,
  parameter int SID_WIDTH = 6
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [NUM_M-1:0]     M_AWVALID,
  output logic [NUM_M-1:0]     M_AWREADY,
  input  logic [NUM_M-1:0]     M_WVALID,
  input  logic [NUM_M-1:0]     M_WLAST,
  output logic [NUM_M-1:0]     M_WREADY,
  output logic [NUM_M-1:0]     M_BVALID,
  input  logic [NUM_M-1:0]     M_BREADY,
  output logic                 S1_AWVALID,
  input  logic                 S1_AWREADY,
  output logic                 S1_WVALID,
  output logic                 S1_WLAST,
  input  logic                 S1_WREADY,
  input  logic                 S1_BVALID,
  input  logic [SID_WIDTH-1:0] S1_BID,
  output logic                 S1_BREADY,
  output logic [MIDX_W-1:0]    grant_idx,
  output logic [NUM_M-1:0]     grant_oh,
  output logic                 busy,
  output logic                 bid_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  state_t              r_state;
  logic [MIDX_W-1:0]   r_rr_ptr;
  logic [MIDX_W-1:0]   r_grant_idx;
  logic [NUM_M-1:0]    r_grant_oh;
  logic                r_bid_err;

  logic                w_st_aw;
  logic                w_st_w;
  logic                w_st_b;
  logic                w_sel_vld;
  logic [MIDX_W-1:0]   w_sel_idx;
  logic [MIDX_W-1:0]   w_cand;
  logic [MIDX_W-1:0]   w_bid_midx;
  logic                w_aw_hs;
  logic                w_w_last_hs;
  logic                w_b_hs;
  logic                w_unused_bid;

  assign w_st_aw    = (r_state == ST_AW);
  assign w_st_w     = (r_state == ST_W);
  assign w_st_b     = (r_state == ST_B);
  assign w_bid_midx = S1_BID[SID_WIDTH-1 -: MIDX_W];
  // Low BID bits belong to the originating master's own ID space; not used here.
  assign w_unused_bid = &{1'b0, S1_BID[SID_WIDTH-MIDX_W-1:0]};

  // Round-robin pick: scan offsets from the highest down so the lowest
  // offset from r_rr_ptr (the first requester at or after it) wins last.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      w_cand = r_rr_ptr + MIDX_W'(k);
      if (M_AWVALID[w_cand]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = w_cand;
      end
    end
  end

  // Combinational handshake gating. grant_oh is nonzero only outside IDLE,
  // and each channel is further qualified by its own state, so a reset
  // (which forces IDLE asynchronously) drops every handshake immediately.
  assign S1_AWVALID = w_st_aw & M_AWVALID[r_grant_idx];
  assign M_AWREADY  = r_grant_oh & {NUM_M{w_st_aw & S1_AWREADY}};

  assign S1_WVALID  = w_st_w & M_WVALID[r_grant_idx];
  assign S1_WLAST   = w_st_w & M_WLAST[r_grant_idx];
  assign M_WREADY   = r_grant_oh & {NUM_M{w_st_w & S1_WREADY}};

  assign M_BVALID   = r_grant_oh & {NUM_M{w_st_b & S1_BVALID}};
  assign S1_BREADY  = w_st_b & M_BREADY[r_grant_idx];

  assign w_aw_hs     = S1_AWVALID & S1_AWREADY;
  assign w_w_last_hs = S1_WVALID & S1_WREADY & S1_WLAST;
  assign w_b_hs      = S1_BVALID & S1_BREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_grant_oh  <= '0;
      r_bid_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_vld) begin
            r_grant_idx <= w_sel_idx;
            r_grant_oh  <= NUM_M'(1) << w_sel_idx;
            r_state     <= ST_AW;
          end
        end
        // A granted master dropping AWVALID is an AXI violation; we simply
        // wait here rather than re-arbitrating.
        ST_AW: begin
          if (w_aw_hs) r_state <= ST_W;
        end
        ST_W: begin
          if (w_w_last_hs) r_state <= ST_B;
        end
        ST_B: begin
          // Misrouted responses are flagged but still delivered to the
          // granted master, since only one write is ever outstanding.
          if (S1_BVALID && (w_bid_midx != r_grant_idx)) r_bid_err <= 1'b1;
          if (w_b_hs) begin
            r_state    <= ST_IDLE;
            r_grant_oh <= '0;
            r_rr_ptr   <= r_grant_idx + MIDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_idx = r_grant_idx;
  assign grant_oh  = r_grant_oh;
  assign busy      = (r_state != ST_IDLE);
  assign bid_err   = r_bid_err;

endmodule

// File: doc/s1_wr_arbiter.md
Name: s1_wr_arbiter

Overview:
Write-path arbiter and sequencer in front of slave port S1 of the 4-master/7-slave AXI NoC. It shares the single S1 write channel (AW, W, B) among NUM_M masters using round-robin arbitration. Once a master is granted, the block locks S1 to that master until the full transaction completes (AW, all W beats, B). It gates the per-master valid/ready handshakes and drives grant_idx, which external AW/W data muxes and B demuxes use for select.

Parameters:
NUM_M, 4, number of requesting masters (power of 2, at least 2)
MIDX_W, 2, log2(NUM_M), master-index field width
SID_WIDTH, 6, S1 ID width; BID[SID_WIDTH-1 -: MIDX_W] carries the originating master index

Ports:
ACLK  input  1  clock, all logic on posedge
ARESETn  input  1  asynchronous active-low reset
M_AWVALID  input  NUM_M  per-master AW request to S1 (already address-decoded)
M_AWREADY  output  NUM_M  per-master AW ready
M_WVALID  input  NUM_M  per-master W valid
M_WLAST  input  NUM_M  per-master W last
M_WREADY  output  NUM_M  per-master W ready
M_BVALID  output  NUM_M  per-master B valid
M_BREADY  input  NUM_M  per-master B ready
S1_AWVALID  output  1  to S1
S1_AWREADY  input  1  from S1
S1_WVALID  output  1  to S1
S1_WLAST  output  1  to S1
S1_WREADY  input  1  from S1
S1_BVALID  input  1  from S1
S1_BID  input  SID_WIDTH  from S1
S1_BREADY  output  1  to S1
grant_idx  output  MIDX_W  registered index of the granted master (mux select)
grant_oh  output  NUM_M  registered one-hot grant, all zero in IDLE
busy  output  1  high in any state other than IDLE
bid_err  output  1  sticky; set when the B master-index field does not equal grant_idx

Behaviour:
- Reset (asynchronous, ARESETn=0): state=IDLE, rr_ptr=0, grant_idx=0, grant_oh=0, busy=0, bid_err=0. All S1_*VALID, S1_BREADY, M_*READY and M_BVALID are 0 through combinational gating. A reset mid-transaction abandons the transaction immediately; there is no drain.
- FSM states: IDLE, AW, W, B. State and grant are registered. Handshake paths are combinational through the grant gates, with zero added latency.
- IDLE: when any M_AWVALID bit is set, select the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_M-1, 0, ...). Register grant_idx and grant_oh, then go to AW on the next edge. Grant latency is 1 cycle. With no request, stay in IDLE.
- AW: S1_AWVALID=M_AWVALID[g]; M_AWREADY[g]=S1_AWREADY; every other M_AWREADY=0. Transition to W on S1_AWVALID&S1_AWREADY.
- W: S1_WVALID=M_WVALID[g]; S1_WLAST=M_WLAST[g]; M_WREADY[g]=S1_WREADY. Each beat transfers on WVALID&WREADY. Transition to B on a beat with WLAST=1. In all other states, every M_WREADY is 0. W data presented by the granted master before its AW completes waits (AXI-legal slave stall).
- B: M_BVALID[g]=S1_BVALID; S1_BREADY=M_BREADY[g]. On S1_BVALID&S1_BREADY: go to IDLE, clear grant_oh, set rr_ptr=(g+1) mod NUM_M. If S1_BID[SID_WIDTH-1 -: MIDX_W] != g during a valid B, set bid_err=1; it stays set until reset. The response is still routed to g.
- Only one write is outstanding on S1. Back-to-back transactions incur one IDLE cycle between the B handshake and the next grant.
- Simultaneous S1_AWREADY and the B handshake cannot occur (states are exclusive). A master deasserting AWVALID while granted violates AXI; the block stays in AW and does not re-arbitrate.
- Fairness: a continuously requesting master waits at most NUM_M-1 transactions.
- Lines not granted and channels not in the active state always see READY=0 and BVALID=0.

Test Plan:
- Reset, then M_AWVALID=4'b0100 with len=0 and BID master field=2 -> grant_idx=2 one cycle later; AW, 1 W beat, B pass through; IDLE; rr_ptr=3; bid_err=0.
- M_AWVALID=4'b1111 held for 4 transactions from rr_ptr=0 -> grant order 0,1,2,3. Repeat from rr_ptr=2 with 4'b1011 -> order 3,0,1.
- Granted master 1 sends a 16-beat burst while S1_WREADY toggles 1,0 -> exactly 16 beats forwarded; the FSM enters B only on WLAST; M_WREADY[0,2,3]=0 throughout.
- Granted master 0 receives a B whose S1_BID master field=3 -> M_BVALID[0] asserted, M_BVALID[3]=0, bid_err=1 and it stays 1 through later transactions.
- ARESETn pulsed low during beat 5 of 8 in the W state -> all outputs 0 the same cycle; after release, the FSM is in IDLE with rr_ptr=0 and a new request from master 3 is granted normally.
- A request from master 2 arrives during master 0's B state -> master 2 is not granted until the cycle after the B handshake, with exactly one IDLE cycle in between.
